// File: rtl/axi_ar_route_tracker.sv
// axi_ar_route_tracker
// ---------------------------------------------------------------------------
// Purpose: sits after the 3-master AR arbiter of a crossbar slave port. It
// forwards the granted AR beat to the slave unchanged. It records which master
// was granted in an in-order tracking FIFO. It then steers the slave's R beats
// back to that master, and pops the FIFO entry on the last beat of each burst.
//
// Ports:
//   clk, reset (async, active-low)
//   io_input_*      : AR from the arbiter plus io_input_chosen (granted master)
//   io_ar_*         : AR to the slave (payload passes straight through)
//   io_r_*          : R from the slave
//   io_outputs_k_*  : R to master k (k = 0..2), payload broadcast to all three
//   io_outstanding  : tracking FIFO occupancy
//   io_len_error    : sticky burst-length mismatch flag (optional, see below)
//
// Optional feature macro: AXI_AR_ROUTE_LEN_CHECK_EN
//   When defined, each entry also stores the AR len, R beats of the head
//   burst are counted, and io_len_error flags bursts whose last beat arrives
//   early or late. Routing is never affected by the flag.
// ---------------------------------------------------------------------------
module axi_ar_route_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    io_input_valid,
    output logic                    io_input_ready,
    input  logic [19:0]             io_input_payload_addr,
    input  logic [3:0]              io_input_payload_id,
    input  logic [7:0]              io_input_payload_len,
    input  logic [2:0]              io_input_payload_size,
    input  logic [1:0]              io_input_payload_burst,
    input  logic [1:0]              io_input_chosen,

    output logic                    io_ar_valid,
    input  logic                    io_ar_ready,
    output logic [19:0]             io_ar_payload_addr,
    output logic [3:0]              io_ar_payload_id,
    output logic [7:0]              io_ar_payload_len,
    output logic [2:0]              io_ar_payload_size,
    output logic [1:0]              io_ar_payload_burst,

    input  logic                    io_r_valid,
    output logic                    io_r_ready,
    input  logic [DATA_WIDTH-1:0]   io_r_payload_data,
    input  logic [3:0]              io_r_payload_id,
    input  logic [1:0]              io_r_payload_resp,
    input  logic                    io_r_payload_last,

    output logic                    io_outputs_0_valid,
    input  logic                    io_outputs_0_ready,
    output logic [DATA_WIDTH-1:0]   io_outputs_0_payload_data,
    output logic [3:0]              io_outputs_0_payload_id,
    output logic [1:0]              io_outputs_0_payload_resp,
    output logic                    io_outputs_0_payload_last,

    output logic                    io_outputs_1_valid,
    input  logic                    io_outputs_1_ready,
    output logic [DATA_WIDTH-1:0]   io_outputs_1_payload_data,
    output logic [3:0]              io_outputs_1_payload_id,
    output logic [1:0]              io_outputs_1_payload_resp,
    output logic                    io_outputs_1_payload_last,

    output logic                    io_outputs_2_valid,
    input  logic                    io_outputs_2_ready,
    output logic [DATA_WIDTH-1:0]   io_outputs_2_payload_data,
    output logic [3:0]              io_outputs_2_payload_id,
    output logic [1:0]              io_outputs_2_payload_resp,
    output logic                    io_outputs_2_payload_last,

    output logic [$clog2(DEPTH):0]  io_outstanding
`ifdef AXI_AR_ROUTE_LEN_CHECK_EN
    ,
    output logic                    io_len_error
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]       r_route [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_head;
    logic [1:0]       w_chosen;
    logic             w_push;
    logic             w_r_ready;
    logic             w_r_fire;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_route[r_rd_ptr];

    // Index 3 never names a real master, so it is folded onto master 2.
    assign w_chosen = (io_input_chosen == 2'd3) ? 2'd2 : io_input_chosen;

    // AR path: zero-latency pass-through, gated only by a full tracker.
    // A pop in the same cycle does not free a slot for the push (no bypass).
    assign io_ar_valid         = io_input_valid && !w_full;
    assign io_input_ready      = io_ar_ready && !w_full;
    assign io_ar_payload_addr  = io_input_payload_addr;
    assign io_ar_payload_id    = io_input_payload_id;
    assign io_ar_payload_len   = io_input_payload_len;
    assign io_ar_payload_size  = io_input_payload_size;
    assign io_ar_payload_burst = io_input_payload_burst;

    assign w_push = io_input_valid && !w_full && io_ar_ready;

    // R path: with nothing tracked the slave is stalled rather than dropped.
    always_comb begin
        w_r_ready = 1'b0;
        if (!w_empty) begin
            case (w_head)
                2'd0:    w_r_ready = io_outputs_0_ready;
                2'd1:    w_r_ready = io_outputs_1_ready;
                default: w_r_ready = io_outputs_2_ready;
            endcase
        end
    end

    assign io_r_ready = w_r_ready;
    assign w_r_fire   = io_r_valid && w_r_ready;
    assign w_pop      = w_r_fire && io_r_payload_last;

    assign io_outputs_0_valid = !w_empty && io_r_valid && (w_head == 2'd0);
    assign io_outputs_1_valid = !w_empty && io_r_valid && (w_head == 2'd1);
    assign io_outputs_2_valid = !w_empty && io_r_valid && (w_head == 2'd2);

    assign io_outputs_0_payload_data = io_r_payload_data;
    assign io_outputs_0_payload_id   = io_r_payload_id;
    assign io_outputs_0_payload_resp = io_r_payload_resp;
    assign io_outputs_0_payload_last = io_r_payload_last;
    assign io_outputs_1_payload_data = io_r_payload_data;
    assign io_outputs_1_payload_id   = io_r_payload_id;
    assign io_outputs_1_payload_resp = io_r_payload_resp;
    assign io_outputs_1_payload_last = io_r_payload_last;
    assign io_outputs_2_payload_data = io_r_payload_data;
    assign io_outputs_2_payload_id   = io_r_payload_id;
    assign io_outputs_2_payload_resp = io_r_payload_resp;
    assign io_outputs_2_payload_last = io_r_payload_last;

    assign io_outstanding = r_count;

    // Tracking FIFO: DEPTH is a power of two, so pointers wrap by overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_route[i] <= 2'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_route[r_wr_ptr] <= w_chosen;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AXI_AR_ROUTE_LEN_CHECK_EN
    logic [7:0] r_len [DEPTH];
    logic [8:0] r_beat_cnt;
    logic       r_len_error;
    logic [8:0] w_head_len;
    logic       w_len_bad;

    assign w_head_len = {1'b0, r_len[r_rd_ptr]};

    // r_beat_cnt holds the number of beats already accepted for the head
    // burst, so the last beat must see exactly len of them before it.
    assign w_len_bad = w_r_fire &&
                       (io_r_payload_last ? (r_beat_cnt != w_head_len)
                                          : (r_beat_cnt == w_head_len));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_len[i] <= 8'd0;
            end
            r_beat_cnt  <= 9'd0;
            r_len_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_len[r_wr_ptr] <= io_input_payload_len;
            end
            if (w_pop) begin
                r_beat_cnt <= 9'd0;
            end else if (w_r_fire) begin
                r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            if (w_len_bad) begin
                r_len_error <= 1'b1;
            end
        end
    end

    assign io_len_error = r_len_error;
`endif

endmodule
